// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issuer: ALU opcodes, request ops,
// status bit positions and issuer FSM states.
package alu_pkg;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam int ST_Z = 2;
  localparam int ST_V = 1;
  localparam int ST_N = 0;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_MVN  = 3'd3,
    OP_CMP  = 3'd4,
    OP_MOV  = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RSV7 = 3'd7
  } req_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } iss_state_e;

  // MOV rides the adder with Ain forced to zero; reserved ops idle on ADD.
  function automatic logic [1:0] op_to_aluop(req_op_e op);
    logic [1:0] r;
    r = ALU_ADD;
    unique case (1'b1)
      (op == OP_SUB),
      (op == OP_CMP): r = ALU_SUB;
      (op == OP_AND): r = ALU_AND;
      (op == OP_MVN): r = ALU_NOTB;
      default:        r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bin_shifter.sv
// Combinational one-bit pre-shifter for ALU operand B.
// Codes: 00 none, 01 LSL1, 10 LSR1, 11 ASR1.
module bin_shifter #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_shift,
  output logic [WIDTH-1:0] o_b
);

  always_comb begin
    o_b = i_b;
    unique case (i_shift)
      2'b01:   o_b = {i_b[WIDTH-2:0], 1'b0};
      2'b10:   o_b = {1'b0, i_b[WIDTH-1:1]};
      2'b11:   o_b = {i_b[WIDTH-1], i_b[WIDTH-1:1]};
      default: o_b = i_b;
    endcase
  end

endmodule

// File: rtl/alu_issue_seq.sv
// Request/response issuer in front of the combinational ALU; owns status_q.
// Optional B pre-shift enabled by defining ALU_ISSUE_SHIFT_EN.
module alu_issue_seq
  import alu_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter bit STATUS_ON_ALL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [1:0]       req_shift,
  output logic [WIDTH-1:0] alu_ain,
  output logic [WIDTH-1:0] alu_bin,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [2:0]       alu_status,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_wr,
  output logic             rsp_err,
  output logic [2:0]       status_q,
  output logic             cond_eq,
  output logic             cond_ne,
  output logic             cond_lt,
  output logic             cond_le
);

  iss_state_e       r_state;
  iss_state_e       w_next;
  req_op_e          r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_aluop;
  logic [WIDTH-1:0] r_data;
  logic             r_wr;
  logic             r_err;
  logic [2:0]       r_status;
  logic [WIDTH-1:0] w_bin;
  logic             w_accept;
  logic             w_rsv;
  logic             w_cmp;
  logic             w_upd;
  logic             w_lt;

  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_rsv    = (r_op == OP_RSV6) || (r_op == OP_RSV7);
  assign w_cmp    = (r_op == OP_CMP);
  assign w_upd    = !w_rsv && (STATUS_ON_ALL || w_cmp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (req_valid) w_next = S_EXEC;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture: only IDLE looks at req_*.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op    <= OP_ADD;
      r_a     <= '0;
      r_b     <= '0;
      r_aluop <= ALU_ADD;
    end else if (w_accept) begin
      r_op    <= req_op_e'(req_op);
      r_a     <= req_a;
      r_b     <= req_b;
      r_aluop <= op_to_aluop(req_op_e'(req_op));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data   <= '0;
      r_wr     <= 1'b0;
      r_err    <= 1'b0;
      r_status <= 3'b000;
    end else if (r_state == S_EXEC) begin
      r_data <= w_rsv ? '0 : alu_out;
      r_wr   <= !(w_rsv || w_cmp);
      r_err  <= w_rsv;
      if (w_upd) r_status <= alu_status;
    end
  end

`ifdef ALU_ISSUE_SHIFT_EN
  logic [1:0] r_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_shift <= 2'b00;
    else if (w_accept) r_shift <= req_shift;
  end

  bin_shifter #(
    .WIDTH (WIDTH)
  ) u_bin_shifter (
    .i_b     (r_b),
    .i_shift (r_shift),
    .o_b     (w_bin)
  );
`else
  logic w_unused_shift;

  assign w_unused_shift = ^req_shift;
  assign w_bin          = r_b;
`endif

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign alu_ain   = (r_op == OP_MOV) ? '0 : r_a;
  assign alu_bin   = w_bin;
  assign alu_op    = r_aluop;
  assign rsp_data  = r_data;
  assign rsp_wr    = r_wr;
  assign rsp_err   = r_err;
  assign status_q  = r_status;

  assign w_lt    = r_status[ST_N] ^ r_status[ST_V];
  assign cond_eq = r_status[ST_Z];
  assign cond_ne = !r_status[ST_Z];
  assign cond_lt = w_lt;
  assign cond_le = r_status[ST_Z] | w_lt;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench: two issuers (status on CMP only / on all ops) each driving its own ALU,
// checked against a signed-arithmetic reference model.
module tb_alu_issue_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [1:0]  req_shift;
  logic        rsp_ready;

  logic        rr0, rr1, rv0, rv1, wr0, wr1, er0, er1;
  logic [15:0] ain0, ain1, bin0, bin1, aout0, aout1, d0, d1;
  logic [1:0]  aop0, aop1;
  logic [2:0]  ast0, ast1, s0, s1;
  logic        eq0, ne0, lt0, le0, eq1, ne1, lt1, le1;
  logic [18:0] w_alu0, w_alu1;

  int checks = 0;
  int errors = 0;
  logic [2:0] st0, st1;

  always #5 clk = ~clk;

  // Behavioural stand-in for the 16-bit ALU: {Z,V,N,out}.
  function automatic logic [18:0] alu_f(logic [15:0] a, logic [15:0] b, logic [1:0] op);
    logic [15:0] o;
    logic v;
    v = 1'b0;
    case (op)
      2'd0: begin o = a + b; v = (a[15] == b[15]) && (o[15] != a[15]); end
      2'd1: begin o = a - b; v = (a[15] != b[15]) && (o[15] != a[15]); end
      2'd2: o = a & b;
      default: o = ~b;
    endcase
    return {(o == 16'h0), v, o[15], o};
  endfunction

  assign w_alu0 = alu_f(ain0, bin0, aop0);
  assign w_alu1 = alu_f(ain1, bin1, aop1);
  assign aout0  = w_alu0[15:0];
  assign ast0   = w_alu0[18:16];
  assign aout1  = w_alu1[15:0];
  assign ast1   = w_alu1[18:16];

  alu_issue_seq #(.WIDTH(16), .STATUS_ON_ALL(1'b0)) u_d0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rr0),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_shift(req_shift),
    .alu_ain(ain0), .alu_bin(bin0), .alu_op(aop0), .alu_out(aout0),
    .alu_status(ast0), .rsp_valid(rv0), .rsp_ready(rsp_ready),
    .rsp_data(d0), .rsp_wr(wr0), .rsp_err(er0), .status_q(s0),
    .cond_eq(eq0), .cond_ne(ne0), .cond_lt(lt0), .cond_le(le0)
  );

  alu_issue_seq #(.WIDTH(16), .STATUS_ON_ALL(1'b1)) u_d1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rr1),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_shift(req_shift),
    .alu_ain(ain1), .alu_bin(bin1), .alu_op(aop1), .alu_out(aout1),
    .alu_status(ast1), .rsp_valid(rv1), .rsp_ready(rsp_ready),
    .rsp_data(d1), .rsp_wr(wr1), .rsp_err(er1), .status_q(s1),
    .cond_eq(eq1), .cond_ne(ne1), .cond_lt(lt1), .cond_le(le1)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        wr;
    logic        err;
    logic        upd;
    logic [2:0]  st;
    logic [1:0]  aop;
    logic [15:0] ain;
    logic [15:0] bin;
  } exp_t;

  // Reference: signed integer arithmetic, results reduced modulo 2^16.
  function automatic exp_t ref_model(int op, int a, int b, int sh);
    exp_t e;
    int bb, sa, sb, s, d;
    bit v, arith;
    bb = b;
`ifdef ALU_ISSUE_SHIFT_EN
    case (sh)
      1: bb = (b * 2) % 65536;
      2: bb = b / 2;
      3: bb = b / 2 + ((b >= 32768) ? 32768 : 0);
      default: bb = b;
    endcase
`else
    if (sh < 0) bb = b;
`endif
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (bb >= 32768) ? bb - 65536 : bb;
    e = '0;
    e.ain = a[15:0];
    e.bin = bb[15:0];
    e.wr = 1'b1;
    e.upd = 1'b1;
    arith = 1'b1;
    s = 0;
    d = 0;
    case (op)
      0: begin s = sa + sb; e.aop = 2'd0; end
      1: begin s = sa - sb; e.aop = 2'd1; end
      4: begin s = sa - sb; e.aop = 2'd1; e.wr = 1'b0; end
      5: begin s = sb; e.aop = 2'd0; e.ain = 16'h0; end
      2: begin arith = 1'b0; d = a & bb; e.aop = 2'd2; end
      3: begin arith = 1'b0; d = 65535 - bb; e.aop = 2'd3; end
      default: begin
        arith = 1'b0; d = 0; e.aop = 2'd0;
        e.wr = 1'b0; e.err = 1'b1; e.upd = 1'b0;
      end
    endcase
    v = 1'b0;
    if (arith) begin
      v = (s > 32767) || (s < -32768);
      d = (s + 131072) % 65536;
    end
    e.data = d[15:0];
    e.st = {(d == 0), v, (d >= 32768)};
    return e;
  endfunction

  function automatic logic [3:0] cnd(logic [2:0] st);
    logic z, signed_less;
    z = st[2];
    signed_less = (st[0] != st[1]);
    return {z, !z, signed_less, z || signed_less};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(string tag);
    chk(tag, {rv0, wr0, er0, d0, s0, aop0, ain0, bin0, rr0},
        {3'b000, 16'h0, 3'b000, 2'b00, 16'h0, 16'h0, 1'b1});
    chk(tag, {rv1, wr1, er1, d1, s1, aop1, ain1, bin1, rr1},
        {3'b000, 16'h0, 3'b000, 2'b00, 16'h0, 16'h0, 1'b1});
  endtask

  task automatic run_op(int op, int a, int b, int sh, int stall);
    exp_t e;
    logic [2:0] x0, x1;
    e = ref_model(op, a, b, sh);
    x0 = st0;
    x1 = st1;
    if (e.upd) begin
      x1 = e.st;
      if (op == 4) x0 = e.st;
    end
    @(negedge clk);
    chk("req_ready_idle", {rr0, rr1}, 2'b11);
    req_valid = 1'b1;
    req_op    = op[2:0];
    req_a     = a[15:0];
    req_b     = b[15:0];
    req_shift = sh[1:0];
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_op    = 3'($urandom);
    req_a     = 16'($urandom);
    req_b     = 16'($urandom);
    req_shift = 2'($urandom);
    chk("exec_valid", {rv0, rv1, rr0, rr1}, 4'b0000);
    chk("exec_alu_op", {aop0, aop1}, {e.aop, e.aop});
    chk("exec_alu_ain", {ain0, ain1}, {e.ain, e.ain});
    chk("exec_alu_bin", {bin0, bin1}, {e.bin, e.bin});
    @(posedge clk);
    #1;
    for (int i = 0; i <= stall; i++) begin
      chk("rsp_valid", {rv0, rv1, rr0, rr1}, 4'b1100);
      chk("rsp_data", {d0, d1}, {e.data, e.data});
      chk("rsp_wr_err", {wr0, er0, wr1, er1}, {e.wr, e.err, e.wr, e.err});
      chk("status_q", {s0, s1}, {x0, x1});
      chk("cond", {eq0, ne0, lt0, le0, eq1, ne1, lt1, le1}, {cnd(x0), cnd(x1)});
      if (i < stall) begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    st0 = x0;
    st1 = x1;
    chk("post_handshake", {rv0, rv1, rr0, rr1}, 4'b0011);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_a     = 16'h0;
    req_b     = 16'h0;
    req_shift = 2'd0;
    rsp_ready = 1'b0;
    st0 = 3'b000;
    st1 = 3'b000;
    #1;
    chk_reset_outs("reset_state");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_op(0, 16'h7FFF, 16'h0001, 0, 0);
    run_op(4, 16'h0005, 16'h0005, 0, 0);
    run_op(4, 16'h8000, 16'h0001, 0, 1);
    run_op(0, 16'h0000, 16'h0000, 0, 0);
    run_op(5, 16'hABCD, 16'h1234, 0, 5);
    run_op(7, 16'h1111, 16'h2222, 0, 0);
    run_op(6, 16'hFFFF, 16'hFFFF, 0, 1);
    run_op(3, 16'h0000, 16'h8001, 3, 0);
    run_op(1, 16'h8000, 16'h0001, 1, 0);
    run_op(2, 16'hF0F0, 16'hFF00, 2, 0);

    for (int n = 0; n < 40; n++) begin
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)),
             int'($urandom_range(0, 65535)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)));
    end

    run_op(4, 16'h0005, 16'h0005, 0, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd0;
    req_a     = 16'h1234;
    req_b     = 16'h4321;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("exec_before_reset", {rv0, rr0}, 2'b00);
    reset = 1'b1;
    #1;
    chk_reset_outs("reset_in_exec");
    @(posedge clk);
    #1;
    chk_reset_outs("reset_held");
    @(negedge clk);
    reset = 1'b0;
    st0 = 3'b000;
    st1 = 3'b000;
    run_op(1, 16'h0003, 16'h0005, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
